// File: rtl/ring_phase_monitor.sv
// Lock and health monitor for a one-hot ring counter bus: tracks phase,
// counts completed revolutions and flags/counts illegal ring transitions.
module ring_phase_monitor #(
  parameter int N    = 4,
  parameter int IDXW = 2,
  parameter int REVW = 8,
  parameter int ERRW = 4
) (
  input  logic            clock,
  input  logic            _reset,
  input  logic            en,
  input  logic [N-1:0]    ring,
  output logic [IDXW-1:0] phase,
  output logic            locked,
  output logic            rev_tick,
  output logic [REVW-1:0] rev_count,
  output logic            err,
  output logic [ERRW-1:0] err_count
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t          state, state_next;
  logic [N-1:0]    prev;
  logic [N-1:0]    exp_ring;
  logic            onehot;
  logic            match;
  logic            load;
  logic            err_hit;
  logic            rev_hit;
  logic [IDXW-1:0] ring_idx;

  always_comb begin
    exp_ring = {prev[0], prev[N-1:1]};
    match    = (ring == exp_ring);
    onehot   = $onehot(ring);
  end

  // Index counted from the MSB so that 1000 maps to phase 0.
  always_comb begin
    ring_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ring[i]) ring_idx = IDXW'(N - 1 - i);
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    err_hit    = 1'b0;
    rev_hit    = 1'b0;
    if (en) begin
      unique case (state)
        HUNT: begin
          if (onehot) begin
            load       = 1'b1;
            state_next = SYNC;
          end
        end
        SYNC: begin
          if (match) begin
            load       = 1'b1;
            state_next = LOCKED;
          end else if (onehot) begin
            load = 1'b1;
          end else begin
            state_next = HUNT;
          end
        end
        LOCKED: begin
          // A match implies one-hot here because prev is always one-hot once loaded.
          if (match) begin
            load    = 1'b1;
            rev_hit = ring[N-1];
          end else begin
            err_hit    = 1'b1;
            state_next = HUNT;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state     <= HUNT;
      prev      <= '0;
      phase     <= '0;
      locked    <= 1'b0;
      rev_tick  <= 1'b0;
      rev_count <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state    <= state_next;
      locked   <= (state_next == LOCKED);
      rev_tick <= rev_hit;
      err      <= err_hit;
      if (load) begin
        prev  <= ring;
        phase <= ring_idx;
      end
      if (rev_hit) rev_count <= rev_count + 1'b1;
      if (err_hit && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule
